load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 158 +++++++++++++++
 tb/tb_load_store_unit.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// RV32I load/store unit: single-port data memory, byte/halfword loads with extension,
// sub-word stores via read-modify-write, misalignment and illegal-width faults.
module load_store_unit #(
  parameter int WORD_ADDR = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        resp_valid,
  output logic [31:0] rdata,
  output logic        fault,
  output logic [31:0] mem_address,
  output logic [31:0] mem_store_data,
  output logic        mem_write,
  output logic        mem_read,
  input  logic [31:0] mem_load_data
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOAD     = 3'd1;
  localparam logic [2:0] S_RMW_READ = 3'd2;
  localparam logic [2:0] S_WRITE    = 3'd3;
  localparam logic [2:0] S_RESP     = 3'd4;

  logic [2:0]  state_q;
  logic        is_store_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] word_q;
  logic [31:0] rdata_q;
  logic        fault_q;

  // Extract and extend the addressed lane of a loaded word.
  function automatic logic [31:0] extract_load(input logic [31:0] word,
                                               input logic [2:0]  f3,
                                               input logic [1:0]  lane);
    logic [31:0]        shifted;
    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;
    logic [31:0]        res;
    shifted = word >> {lane, 3'b000};
    byte_s  = shifted[7:0];
    half_s  = shifted[15:0];
    case (f3)
      3'd0:    res = 32'(byte_s);
      3'd1:    res = 32'(half_s);
      3'd2:    res = word;
      3'd4:    res = {24'd0, shifted[7:0]};
      3'd5:    res = {16'd0, shifted[15:0]};
      default: res = 32'd0;
    endcase
    return res;
  endfunction

  // Replace the addressed byte/halfword lane of the captured word with store data.
  function automatic logic [31:0] merge_store(input logic [31:0] word,
                                              input logic [31:0] wd,
                                              input logic [2:0]  f3,
                                              input logic [1:0]  lane);
    logic [31:0] mask;
    logic [31:0] ins;
    logic [31:0] res;
    case (f3)
      3'd0: begin
        mask = 32'h0000_00FF << {lane, 3'b000};
        ins  = {24'd0, wd[7:0]} << {lane, 3'b000};
        res  = (word & ~mask) | (ins & mask);
      end
      3'd1: begin
        mask = 32'h0000_FFFF << {lane[1], 4'b0000};
        ins  = {16'd0, wd[15:0]} << {lane[1], 4'b0000};
        res  = (word & ~mask) | (ins & mask);
      end
      default: res = wd;
    endcase
    return res;
  endfunction

  function automatic logic req_faults(input logic        st,
                                      input logic [2:0]  f3,
                                      input logic [1:0]  a);
    logic illegal;
    logic misaligned;
    illegal    = st ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    misaligned = (f3[1:0] == 2'b01 && a[0]) || (f3[1:0] == 2'b10 && a != 2'b00);
    return illegal || misaligned;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      is_store_q <= 1'b0;
      funct3_q   <= 3'd0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      rdata_q    <= 32'd0;
      fault_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            is_store_q <= is_store;
            funct3_q   <= funct3;
            addr_q     <= addr;
            wdata_q    <= wdata;
            if (req_faults(is_store, funct3, addr[1:0])) begin
              state_q <= S_RESP;
              rdata_q <= 32'd0;
              fault_q <= 1'b1;
            end else if (!is_store) begin
              state_q <= S_LOAD;
            end else if (funct3[1:0] == 2'b10) begin
              state_q <= S_WRITE;
            end else begin
              state_q <= S_RMW_READ;
            end
          end
        end
        S_LOAD: begin
          rdata_q <= extract_load(mem_load_data, funct3_q, addr_q[1:0]);
          fault_q <= 1'b0;
          state_q <= S_RESP;
        end
        S_RMW_READ: state_q <= S_WRITE;
        S_WRITE: begin
          rdata_q <= 32'd0;
          fault_q <= 1'b0;
          state_q <= S_RESP;
        end
        S_RESP:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Merge word is plain data; it is always rewritten by RMW_READ before use.
  always_ff @(posedge clk) begin
    if (state_q == S_RMW_READ) word_q <= mem_load_data;
  end

  always_comb begin
    req_ready      = !rst && (state_q == S_IDLE);
    resp_valid     = !rst && (state_q == S_RESP);
    mem_read       = !rst && (state_q == S_LOAD || state_q == S_RMW_READ);
    mem_write      = !rst && (state_q == S_WRITE) && is_store_q;
    rdata          = rdata_q;
    fault          = fault_q;
    mem_address    = (WORD_ADDR != 0) ? {2'b00, addr_q[31:2]} : {addr_q[31:2], 2'b00};
    mem_store_data = merge_store(word_q, wdata_q, funct3_q, addr_q[1:0]);
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit against a small word-addressed memory model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        resp_valid;
  logic [31:0] rdata;
  logic        fault;
  logic [31:0] mem_address;
  logic [31:0] mem_store_data;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] mem_load_data;

  logic [31:0] mem [0:15];

  int n_vec  = 0;
  int n_miss = 0;
  int n_rd   = 0;
  int n_wr   = 0;
  int n_resp = 0;
  logic        overlap = 1'b0;
  logic [31:0] rd_addr;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;

  load_store_unit #(.WORD_ADDR(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .is_store(is_store), .funct3(funct3), .addr(addr), .wdata(wdata),
    .resp_valid(resp_valid), .rdata(rdata), .fault(fault),
    .mem_address(mem_address), .mem_store_data(mem_store_data),
    .mem_write(mem_write), .mem_read(mem_read), .mem_load_data(mem_load_data)
  );

  always #5 clk = ~clk;

  assign mem_load_data = mem[mem_address[3:0]];

  always @(posedge clk) begin
    if (mem_write) mem[mem_address[3:0]] <= mem_store_data;
  end

  always @(negedge clk) begin
    if (mem_read)  begin n_rd++; rd_addr = mem_address; end
    if (mem_write) begin n_wr++; wr_addr = mem_address; wr_data = mem_store_data; end
    if (mem_read && mem_write) overlap = 1'b1;
    if (resp_valid) n_resp++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one request and wait for its response; lat = edges from acceptance (11 = none).
  task automatic run_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output int lat,
                         output logic [31:0] rd, output logic flt,
                         output int reads, output int writes);
    int g;
    int r0;
    int w0;
    @(negedge clk);
    is_store = st; funct3 = f3; addr = a; wdata = wd; req_valid = 1'b1;
    g = 0;
    while (!req_ready && g < 20) begin @(negedge clk); g++; end
    r0 = n_rd; w0 = n_wr;
    @(posedge clk);
    #1 req_valid = 1'b0;
    rd = 32'hxxxx_xxxx; flt = 1'bx;
    for (lat = 1; lat <= 10; lat++) begin
      @(negedge clk);
      if (resp_valid) begin rd = rdata; flt = fault; break; end
    end
    reads = n_rd - r0; writes = n_wr - w0;
  endtask

  int          lat;
  logic [31:0] rd;
  logic        flt;
  int          nr;
  int          nw;
  int          k;
  int          resp_before;
  int          wr_before;

  initial begin
    mem[0] = 32'h8070_60F0;
    mem[1] = 32'h1122_3344;
    mem[2] = 32'h0000_0000;
    mem[3] = 32'hCAFE_F00D;
    for (int i = 4; i < 16; i++) mem[i] = 32'd0;
    rst = 1'b1; req_valid = 1'b0; is_store = 1'b0; funct3 = 3'd0; addr = 32'd0; wdata = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_ready",  {31'd0, req_ready}, 32'd0);
    check_eq("rst_resp",   {31'd0, resp_valid}, 32'd0);
    check_eq("rst_rdata",  rdata, 32'd0);
    check_eq("rst_fault",  {31'd0, fault}, 32'd0);
    check_eq("rst_strobe", {30'd0, mem_read, mem_write}, 32'd0);
    rst = 1'b0;
    #1 check_eq("ready_after_rst", {31'd0, req_ready}, 32'd1);

    run_req(1'b0, 3'd2, 32'h0, 32'h0, lat, rd, flt, nr, nw);
    check_eq("lw_lat",   lat, 2);
    check_eq("lw_rdata", rd, 32'h8070_60F0);
    check_eq("lw_fault", {31'd0, flt}, 32'd0);
    check_eq("lw_reads", nr, 1);
    check_eq("lw_raddr", rd_addr, 32'd0);

    run_req(1'b0, 3'd0, 32'h3, 32'h0, lat, rd, flt, nr, nw);
    check_eq("lb3",  rd, 32'hFFFF_FF80);
    run_req(1'b0, 3'd4, 32'h3, 32'h0, lat, rd, flt, nr, nw);
    check_eq("lbu3", rd, 32'h0000_0080);
    run_req(1'b0, 3'd5, 32'h2, 32'h0, lat, rd, flt, nr, nw);
    check_eq("lhu2", rd, 32'h0000_8070);
    run_req(1'b0, 3'd1, 32'h2, 32'h0, lat, rd, flt, nr, nw);
    check_eq("lh2",  rd, 32'hFFFF_8070);
    run_req(1'b0, 3'd0, 32'h0, 32'h0, lat, rd, flt, nr, nw);
    check_eq("lb0",  rd, 32'hFFFF_FFF0);
    run_req(1'b0, 3'd4, 32'h1, 32'h0, lat, rd, flt, nr, nw);
    check_eq("lbu1", rd, 32'h0000_0060);

    run_req(1'b1, 3'd0, 32'h5, 32'hAB, lat, rd, flt, nr, nw);
    check_eq("sb_lat",    lat, 3);
    check_eq("sb_reads",  nr, 1);
    check_eq("sb_writes", nw, 1);
    check_eq("sb_waddr",  wr_addr, 32'd1);
    check_eq("sb_wdata",  wr_data, 32'h1122_AB44);
    check_eq("sb_rdata",  rd, 32'd0);

    run_req(1'b1, 3'd1, 32'hE, 32'h1234, lat, rd, flt, nr, nw);
    check_eq("sh_lat",   lat, 3);
    check_eq("sh_wdata", wr_data, 32'h1234_F00D);
    run_req(1'b1, 3'd0, 32'hC, 32'h5599, lat, rd, flt, nr, nw);
    check_eq("sb0_wdata", wr_data, 32'h1234_F099);

    run_req(1'b0, 3'd2, 32'h0, 32'h0, lat, rd, flt, nr, nw);
    run_req(1'b0, 3'd2, 32'h6, 32'h0, lat, rd, flt, nr, nw);
    check_eq("flt_lw_lat",   lat, 1);
    check_eq("flt_lw_fault", {31'd0, flt}, 32'd1);
    check_eq("flt_lw_rdata", rd, 32'd0);
    check_eq("flt_lw_strb",  nr + nw, 0);
    @(negedge clk);
    check_eq("flt_hold", {31'd0, fault}, 32'd1);
    run_req(1'b1, 3'd1, 32'h1, 32'hFFFF, lat, rd, flt, nr, nw);
    check_eq("flt_sh_lat",   lat, 1);
    check_eq("flt_sh_fault", {31'd0, flt}, 32'd1);
    check_eq("flt_sh_strb",  nr + nw, 0);
    run_req(1'b0, 3'd3, 32'h0, 32'h0, lat, rd, flt, nr, nw);
    check_eq("flt_f3_lat",   lat, 1);
    check_eq("flt_f3_fault", {31'd0, flt}, 32'd1);
    check_eq("flt_f3_strb",  nr + nw, 0);
    run_req(1'b1, 3'd4, 32'h0, 32'h0, lat, rd, flt, nr, nw);
    check_eq("flt_st4_fault", {31'd0, flt}, 32'd1);

    // Reset during the read half of a halfword store.
    @(negedge clk);
    is_store = 1'b1; funct3 = 3'd1; addr = 32'h6; wdata = 32'hBEEF; req_valid = 1'b1;
    resp_before = n_resp; wr_before = n_wr;
    @(posedge clk);
    #1 req_valid = 1'b0; rst = 1'b1;
    #1 check_eq("rst_mid_read", {31'd0, mem_read}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rst_mid_ready", {31'd0, req_ready}, 32'd1);
    repeat (4) @(negedge clk);
    check_eq("rst_mid_nowr",   n_wr - wr_before, 0);
    check_eq("rst_mid_noresp", n_resp - resp_before, 0);
    run_req(1'b0, 3'd2, 32'h4, 32'h0, lat, rd, flt, nr, nw);
    check_eq("rst_mid_word", rd, 32'h1122_AB44);

    // Back-to-back store then load, valid held high.
    @(negedge clk);
    is_store = 1'b1; funct3 = 3'd2; addr = 32'h8; wdata = 32'hDEAD_BEEF; req_valid = 1'b1;
    @(posedge clk);
    #1 is_store = 1'b0; wdata = 32'd0;
    k = 0;
    do begin @(negedge clk); k++; end while (!req_ready && k < 10);
    check_eq("b2b_gap", k, 3);
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (lat = 1; lat <= 10; lat++) begin
      @(negedge clk);
      if (resp_valid) break;
    end
    check_eq("b2b_lat",   lat, 2);
    check_eq("b2b_rdata", rdata, 32'hDEAD_BEEF);

    check_eq("rw_overlap", {31'd0, overlap}, 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
